// File: rtl/tlb_assoc.sv
// tlb_assoc: N-way set-associative Sv39 TLB with a valid/ready lookup port.
// Misses are resolved by an external page-table walker; the returned leaf PTE is installed
// into the way chosen by a per-set round-robin pointer.
module tlb_assoc #(
   parameter int unsigned WAYS      = 2,
   parameter int unsigned SETS      = 64,
   parameter int unsigned VA_WIDTH  = 64,
   parameter int unsigned PA_WIDTH  = 56,
   parameter int unsigned PAGE_BITS = 12
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                translate_en,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [VA_WIDTH-1:0] req_vaddr,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [PA_WIDTH-1:0] resp_paddr,
   output logic                resp_fault,
   input  logic                flush,
   output logic                walk_valid,
   output logic [26:0]         walk_vpn,
   input  logic                walk_done,
   input  logic [63:0]         walk_pte,
   input  logic                walk_fault
);

   localparam int unsigned IdxW  = $clog2(SETS);
   localparam int unsigned WayW  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int unsigned TagLo = PAGE_BITS + IdxW;
   localparam int unsigned TagW  = 39 - TagLo;
   localparam int unsigned PpnW  = 44;

   typedef enum logic [1:0] {StIdle, StLookup, StWalk, StResp} state_e;

   state_e                state_q, state_d;
   logic [VA_WIDTH-1:0]   vaddr_q, vaddr_d;
   logic                  bypass_q, bypass_d;
   logic                  pend_q, pend_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [PA_WIDTH-1:0]   resp_paddr_q, resp_paddr_d;
   logic                  resp_fault_q, resp_fault_d;
   logic                  walk_valid_q, walk_valid_d;
   logic [26:0]           walk_vpn_q, walk_vpn_d;

   // Entry storage: valid bits and pointers are reset, tag/PPN payload is not.
   logic [WAYS-1:0][SETS-1:0] valid_q;
   logic [SETS-1:0][WayW-1:0] rr_q;
   logic [TagW-1:0]           tag_q [WAYS][SETS];
   logic [PpnW-1:0]           ppn_q [WAYS][SETS];

   logic [IdxW-1:0]           idx;
   logic [TagW-1:0]           tag;
   logic                      hit;
   logic [PpnW-1:0]           hit_ppn;
   logic [WayW-1:0]           fill_way;
   logic [WayW-1:0]           rr_next;
   logic                      fill_en;
   logic                      clear_all;
   logic [PpnW+PAGE_BITS-1:0] hit_pa_full;
   logic [PpnW+PAGE_BITS-1:0] walk_pa_full;
   logic                      unused_bits;

   assign idx          = vaddr_q[TagLo-1:PAGE_BITS];
   assign tag          = vaddr_q[38:TagLo];
   assign fill_way     = rr_q[idx];
   assign rr_next      = (WAYS == 1) ? '0 : fill_way + WayW'(1);
   assign hit_pa_full  = {hit_ppn, vaddr_q[PAGE_BITS-1:0]};
   assign walk_pa_full = {walk_pte[53:10], vaddr_q[PAGE_BITS-1:0]};
   assign unused_bits  = ^{req_vaddr, walk_pte, vaddr_q};

   assign resp_valid = resp_valid_q;
   assign resp_paddr = resp_paddr_q;
   assign resp_fault = resp_fault_q;
   assign walk_valid = walk_valid_q;
   assign walk_vpn   = walk_vpn_q;

   // Parallel tag compare across all ways; the lowest matching way wins.
   always_comb begin
      hit     = 1'b0;
      hit_ppn = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!hit && valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
            hit     = 1'b1;
            hit_ppn = ppn_q[w][idx];
         end
      end
   end

   // Lookup FSM: next state, response/walk registers, fill and flush strobes.
   always_comb begin
      state_d      = state_q;
      vaddr_d      = vaddr_q;
      bypass_d     = bypass_q;
      pend_d       = pend_q;
      resp_valid_d = resp_valid_q;
      resp_paddr_d = resp_paddr_q;
      resp_fault_d = resp_fault_q;
      walk_valid_d = walk_valid_q;
      walk_vpn_d   = walk_vpn_q;
      fill_en      = 1'b0;
      clear_all    = 1'b0;
      req_ready    = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready = !reset && !pend_q && !flush;
            // A new or deferred flush takes this cycle and blocks acceptance.
            if (pend_q || flush) begin
               clear_all = 1'b1;
               pend_d    = 1'b0;
            end else if (req_valid) begin
               vaddr_d  = req_vaddr;
               bypass_d = !translate_en;
               state_d  = StLookup;
            end
         end
         StLookup: begin
            pend_d = pend_q | flush;
            if (bypass_q) begin
               resp_valid_d = 1'b1;
               resp_paddr_d = vaddr_q[PA_WIDTH-1:0];
               resp_fault_d = 1'b0;
               state_d      = StResp;
            end else if (hit) begin
               resp_valid_d = 1'b1;
               resp_paddr_d = PA_WIDTH'(hit_pa_full);
               resp_fault_d = 1'b0;
               state_d      = StResp;
            end else begin
               walk_valid_d = 1'b1;
               walk_vpn_d   = vaddr_q[38:12];
               state_d      = StWalk;
            end
         end
         StWalk: begin
            pend_d = pend_q | flush;
            if (walk_done) begin
               walk_valid_d = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = StResp;
               if (walk_fault) begin
                  resp_paddr_d = '0;
                  resp_fault_d = 1'b1;
               end else begin
                  resp_paddr_d = PA_WIDTH'(walk_pa_full);
                  resp_fault_d = 1'b0;
                  // A flush seen at any point in this operation makes the fill stale.
                  fill_en      = !(pend_q || flush);
               end
            end
         end
         StResp: begin
            pend_d = pend_q | flush;
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         vaddr_q      <= '0;
         bypass_q     <= 1'b0;
         pend_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_paddr_q <= '0;
         resp_fault_q <= 1'b0;
         walk_valid_q <= 1'b0;
         walk_vpn_q   <= '0;
      end else begin
         state_q      <= state_d;
         vaddr_q      <= vaddr_d;
         bypass_q     <= bypass_d;
         pend_q       <= pend_d;
         resp_valid_q <= resp_valid_d;
         resp_paddr_q <= resp_paddr_d;
         resp_fault_q <= resp_fault_d;
         walk_valid_q <= walk_valid_d;
         walk_vpn_q   <= walk_vpn_d;
      end
   end

   // Valid bits and replacement pointers: cleared by reset, flush, updated on fill.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         rr_q    <= '0;
      end else if (clear_all) begin
         valid_q <= '0;
      end else if (fill_en) begin
         valid_q[fill_way][idx] <= 1'b1;
         rr_q[idx]              <= rr_next;
      end
   end

   // Entry payload written into the victim way on fill.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[fill_way][idx] <= tag;
         ppn_q[fill_way][idx] <= walk_pte[53:10];
      end
   end

endmodule

// File: tb/tb_tlb_assoc.sv
// tb_tlb_assoc: randomized and directed bench for tlb_assoc with a transaction-level TLB model.
module tb_tlb_assoc;

   localparam int WAYS = 2;
   localparam int SETS = 64;

   logic        clk = 1'b0;
   logic        reset, translate_en, req_valid, req_ready;
   logic [63:0] req_vaddr;
   logic        resp_valid, resp_ready, resp_fault;
   logic [55:0] resp_paddr;
   logic        flush, walk_valid, walk_done, walk_fault;
   logic [26:0] walk_vpn;
   logic [63:0] walk_pte;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tlb_assoc #(
      .WAYS(WAYS), .SETS(SETS), .VA_WIDTH(64), .PA_WIDTH(56), .PAGE_BITS(12)
   ) dut (
      .clk(clk), .reset(reset), .translate_en(translate_en),
      .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
      .resp_fault(resp_fault), .flush(flush), .walk_valid(walk_valid), .walk_vpn(walk_vpn),
      .walk_done(walk_done), .walk_pte(walk_pte), .walk_fault(walk_fault)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference TLB: per-set list of WAYS slots plus a round-robin victim counter.
   logic        m_valid [SETS][WAYS];
   logic [63:0] m_tag   [SETS][WAYS];
   logic [43:0] m_ppn   [SETS][WAYS];
   int          m_rr    [SETS];

   function automatic int set_of(input logic [63:0] va);
      return int'((va / 64'd4096) % 64'(SETS));
   endfunction

   function automatic logic [63:0] tag_of(input logic [63:0] va);
      return (va % (64'd1 << 39)) / (64'd4096 * 64'(SETS));
   endfunction

   function automatic void model_clear();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
   endfunction

   function automatic void model_reset();
      model_clear();
      for (int s = 0; s < SETS; s++) m_rr[s] = 0;
   endfunction

   function automatic void model_lookup(input logic [63:0] va, output logic hit,
                                        output logic [43:0] ppn);
      int s;
      s   = set_of(va);
      hit = 1'b0;
      ppn = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && m_valid[s][w] && m_tag[s][w] == tag_of(va)) begin
            hit = 1'b1;
            ppn = m_ppn[s][w];
         end
      end
   endfunction

   function automatic void model_fill(input logic [63:0] va, input logic [43:0] ppn);
      int s;
      s                  = set_of(va);
      m_valid[s][m_rr[s]] = 1'b1;
      m_tag[s][m_rr[s]]   = tag_of(va);
      m_ppn[s][m_rr[s]]   = ppn;
      m_rr[s]             = (m_rr[s] + 1) % WAYS;
   endfunction

   // Expected response/walk values, published by the stimulus before they become visible.
   logic        mon_en = 1'b0;
   logic [55:0] exp_paddr = '0;
   logic        exp_fault = 1'b0;
   logic [26:0] exp_vpn = '0;

   // Every cycle the outputs are meaningful, compare them against the model's expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         if (resp_valid) begin
            chkw("mon_paddr", 64'(resp_paddr), 64'(exp_paddr));
            chk1("mon_fault", resp_fault, exp_fault);
         end
         if (walk_valid) chkw("mon_vpn", 64'(walk_vpn), 64'(exp_vpn));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      mon_en = 1'b0; reset = 1'b1; req_valid = 1'b0; flush = 1'b0;
      walk_done = 1'b0; resp_ready = 1'b0;
      #1 chk1("rst_req_ready", req_ready, 1'b0);
      @(negedge clk);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chkw("rst_resp_paddr", 64'(resp_paddr), 64'd0);
      chk1("rst_resp_fault", resp_fault, 1'b0);
      chk1("rst_walk_valid", walk_valid, 1'b0);
      chkw("rst_walk_vpn", 64'(walk_vpn), 64'd0);
      reset = 1'b0;
      #1 chk1("post_rst_ready", req_ready, 1'b1);
      model_reset();
      mon_en = 1'b1;
   endtask

   // One complete request. phase: 0 none, 1 flush in LOOKUP, 2 flush in WALK, 3 flush in RESP.
   task automatic xact(input logic [63:0] va, input logic te, input int wdelay,
                       input logic wfault, input logic [43:0] ppn, input int phase,
                       input int rdelay, input logic idle_fl, output logic got_miss,
                       output logic [55:0] got_pa, output logic got_fault,
                       output logic [26:0] got_vpn);
      logic        mhit;
      logic [43:0] mppn;
      logic [55:0] pa0;
      logic        fl_seen;
      int          n;
      fl_seen = 1'b0;
      got_miss = 1'b0; got_pa = '0; got_fault = 1'b0; got_vpn = '0;
      @(negedge clk);
      if (idle_fl) model_clear();
      if (!te) begin
         mhit      = 1'b1;
         exp_paddr = 56'(va % (64'd1 << 56));
      end else begin
         model_lookup(va, mhit, mppn);
         exp_paddr = 56'({mppn, 12'(va % 64'd4096)});
      end
      exp_fault = 1'b0;
      exp_vpn   = 27'((va % (64'd1 << 39)) / 64'd4096);
      req_valid = 1'b1; req_vaddr = va; translate_en = te; flush = idle_fl;
      #1;
      if (idle_fl) chk1("flush_beats_req", req_ready, 1'b0);
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         flush = 1'b0;
         #1 n++;
      end
      chk1("accept", req_ready, 1'b1);
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0; translate_en = 1'($urandom_range(0, 1));
      chk1("lookup_no_resp", resp_valid, 1'b0);
      chk1("lookup_no_walk", walk_valid, 1'b0);
      if (phase == 1) begin flush = 1'b1; fl_seen = 1'b1; end
      @(negedge clk);
      flush    = 1'b0;
      got_miss = walk_valid;
      got_vpn  = walk_vpn;
      chk1("miss_vs_model", walk_valid, !mhit);
      chk1("hit_latency", resp_valid, mhit);
      if (walk_valid) begin
         if (phase == 2) begin flush = 1'b1; fl_seen = 1'b1; end
         n = 0;
         for (int k = 0; k < wdelay; k++) begin
            @(negedge clk);
            flush = 1'b0;
            if (!walk_valid) n++;
         end
         walk_done = 1'b1; walk_fault = wfault;
         walk_pte  = {10'($urandom), ppn, 10'($urandom)};
         exp_paddr = wfault ? 56'd0 : 56'({ppn, 12'(va % 64'd4096)});
         exp_fault = wfault;
         @(negedge clk);
         walk_done = 1'b0; walk_fault = 1'b0; flush = 1'b0;
         chk1("walk_held", n == 0, 1'b1);
         chk1("walk_dropped", walk_valid, 1'b0);
         chk1("fill_resp_latency", resp_valid, 1'b1);
      end
      n = 0;
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk1("resp_present", resp_valid, 1'b1);
      got_pa = resp_paddr; got_fault = resp_fault; pa0 = resp_paddr;
      if (phase == 3) begin flush = 1'b1; fl_seen = 1'b1; end
      for (int k = 0; k < rdelay; k++) begin
         @(negedge clk);
         flush = 1'b0;
         chk1("bp_valid", resp_valid, 1'b1);
         chkw("bp_stable", 64'(resp_paddr), 64'(pa0));
         chk1("bp_req_ready", req_ready, 1'b0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0; flush = 1'b0;
      #1;
      chk1("resp_dropped", resp_valid, 1'b0);
      chk1("post_req_ready", req_ready, !fl_seen);
      if (!mhit && !wfault && !fl_seen) model_fill(va, ppn);
      if (fl_seen) model_clear();
   endtask

   logic        miss, flt;
   logic [55:0] pa;
   logic [26:0] vpn;
   logic [63:0] tags [5];
   logic [63:0] va;

   initial begin
      reset = 1'b1; translate_en = 1'b1; req_valid = 1'b0; req_vaddr = '0;
      resp_ready = 1'b0; flush = 1'b0; walk_done = 1'b0; walk_pte = '0; walk_fault = 1'b0;
      do_reset();

      // Miss then hit on a known address.
      xact(64'h0000_0040_0012_3456, 1'b1, 5, 1'b0, 44'hABCDE, 0, 0, 1'b0, miss, pa, flt, vpn);
      chk1("t1_miss", miss, 1'b1);
      chkw("t1_vpn", 64'(vpn), 64'h400_0123);
      chkw("t1_paddr", 64'(pa), 64'hABCDE456);
      chk1("t1_fault", flt, 1'b0);
      xact(64'h0000_0040_0012_3456, 1'b1, 0, 1'b0, 44'h0, 0, 0, 1'b0, miss, pa, flt, vpn);
      chk1("t1_rehit", miss, 1'b0);
      chkw("t1_rehit_paddr", 64'(pa), 64'hABCDE456);

      // Three tags into set 5: the third evicts way 0.
      xact(64'h45AAA, 1'b1, 1, 1'b0, 44'h111, 0, 0, 1'b0, miss, pa, flt, vpn);
      xact(64'h85BBB, 1'b1, 2, 1'b0, 44'h222, 0, 0, 1'b0, miss, pa, flt, vpn);
      xact(64'hC5CCC, 1'b1, 0, 1'b0, 44'h333, 0, 0, 1'b0, miss, pa, flt, vpn);
      chk1("rr_third_miss", miss, 1'b1);
      xact(64'h85BBB, 1'b1, 0, 1'b0, 44'h0, 0, 0, 1'b0, miss, pa, flt, vpn);
      chk1("rr_second_hits", miss, 1'b0);
      chkw("rr_second_paddr", 64'(pa), 64'h222BBB);
      xact(64'h45AAA, 1'b1, 0, 1'b0, 44'h444, 0, 0, 1'b0, miss, pa, flt, vpn);
      chk1("rr_first_evicted", miss, 1'b1);

      // Walk fault: nothing installed.
      xact(64'h0777_7123, 1'b1, 3, 1'b1, 44'h999, 0, 0, 1'b0, miss, pa, flt, vpn);
      chk1("fault_flag", flt, 1'b1);
      chkw("fault_paddr", 64'(pa), 64'd0);
      xact(64'h0777_7123, 1'b1, 1, 1'b0, 44'h999, 0, 0, 1'b0, miss, pa, flt, vpn);
      chk1("fault_remiss", miss, 1'b1);

      // Flush while idle.
      xact(64'h0010_1000, 1'b1, 0, 1'b0, 44'h1, 0, 0, 1'b0, miss, pa, flt, vpn);
      xact(64'h0020_2000, 1'b1, 0, 1'b0, 44'h2, 0, 0, 1'b0, miss, pa, flt, vpn);
      @(negedge clk);
      flush = 1'b1;
      #1 chk1("idle_flush_ready", req_ready, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      #1 chk1("idle_flush_ready_back", req_ready, 1'b1);
      model_clear();
      xact(64'h0010_1000, 1'b1, 0, 1'b0, 44'h1, 0, 0, 1'b0, miss, pa, flt, vpn);
      chk1("flushed_p_miss", miss, 1'b1);
      xact(64'h0020_2000, 1'b1, 0, 1'b0, 44'h2, 0, 0, 1'b0, miss, pa, flt, vpn);
      chk1("flushed_q_miss", miss, 1'b1);

      // Flush during walk: result delivered, fill dropped.
      xact(64'h0033_3444, 1'b1, 3, 1'b0, 44'h5A5A5, 2, 0, 1'b0, miss, pa, flt, vpn);
      chkw("walk_flush_paddr", 64'(pa), 64'h5A5A5444);
      xact(64'h0033_3444, 1'b1, 0, 1'b0, 44'h5A5A5, 0, 0, 1'b0, miss, pa, flt, vpn);
      chk1("walk_flush_remiss", miss, 1'b1);

      // Bypass with backpressure.
      xact(64'h1234_5678, 1'b0, 0, 1'b0, 44'h0, 0, 4, 1'b0, miss, pa, flt, vpn);
      chk1("bypass_no_walk", miss, 1'b0);
      chkw("bypass_paddr", 64'(pa), 64'h1234_5678);

      // Flush coinciding with a request wins; the entry is gone when it is accepted.
      xact(64'h0033_3444, 1'b1, 0, 1'b0, 44'h5A5A5, 0, 0, 1'b1, miss, pa, flt, vpn);
      chk1("flush_req_miss", miss, 1'b1);

      // Randomized traffic over a small address pool to force hits, conflicts and evictions.
      for (int i = 0; i < 5; i++) tags[i] = 64'($urandom_range(1, 2000000));
      for (int i = 0; i < 300; i++) begin
         int r, ph;
         va = ({$urandom, $urandom} & ~((64'd1 << 39) - 1))
              | (tags[$urandom_range(0, 4)] << 18)
              | (64'($urandom_range(0, 1) ? 9 : 5) << 12)
              | 64'($urandom_range(0, 4095));
         r  = $urandom_range(0, 15);
         ph = (r < 3) ? r + 1 : 0;
         xact(va, 1'($urandom_range(0, 7) != 0), $urandom_range(0, 4),
              1'($urandom_range(0, 5) == 0), 44'({$urandom, $urandom}), ph,
              $urandom_range(0, 3), 1'($urandom_range(0, 15) == 0), miss, pa, flt, vpn);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case a DUT stall defeats every bounded wait.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "global timeout");
   end

endmodule
